// File: rtl/mem_access_ctrl_if.sv
// M-stage / data-bus signal bundle for mem_access_ctrl.
// master is the controller's view of the bundle; slave is the view of the pipeline and bus that surround it.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              memenM;
  logic              memwriteM;
  logic [1:0]        sizeM;
  logic              unsignedM;
  logic [ADDR_W-1:0] addrM;
  logic [DATA_W-1:0] wdataM;
  logic [DATA_W-1:0] rdataM;
  logic              stall_mem;
  logic              adelM;
  logic              adesM;
  logic              bus_req;
  logic              bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_wstrb;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  memenM, memwriteM, sizeM, unsignedM, addrM, wdataM, bus_ack, bus_rdata,
    output rdataM, stall_mem, adelM, adesM, bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata
  );

  modport slave (
    output memenM, memwriteM, sizeM, unsignedM, addrM, wdataM, bus_ack, bus_rdata,
    input  rdataM, stall_mem, adelM, adesM, bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage data-side controller: store strobes/lane replication, load extraction,
// misalignment detection, and a pipeline stall while the bus transfer is outstanding.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_ctrl_if.master m
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        lo_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mis;
  logic              idle;
  logic              issue;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign mis   = ((m.sizeM == 2'b01) & m.addrM[0]) | (m.sizeM[1] & (m.addrM[1:0] != 2'b00));
  assign idle  = (state_q == IDLE);
  assign issue = idle & m.memenM & ~mis;

  // Combinational outputs are gated by rst so every output reads 0 while reset is held.
  assign m.stall_mem = rst & (issue | (state_q == REQ));
  assign m.adelM     = rst & idle & m.memenM & ~m.memwriteM & mis;
  assign m.adesM     = rst & idle & m.memenM & m.memwriteM & mis;
  assign m.bus_req   = (state_q == REQ);
  assign m.bus_wr    = wr_q;
  assign m.bus_addr  = addr_q;
  assign m.bus_wstrb = wstrb_q;
  assign m.bus_wdata = wdata_q;
  assign m.rdataM    = rdata_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign wstrb_d[gi] = m.memwriteM &
                           ((m.sizeM == 2'b00) ? (m.addrM[1:0] == LANE) :
                            (m.sizeM == 2'b01) ? (m.addrM[1] == LANE[1]) : 1'b1);
      assign wdata_d[8*gi +: 8] = (m.sizeM == 2'b00) ? m.wdataM[7:0] :
                                  (m.sizeM == 2'b01) ? m.wdataM[8*(gi%2) +: 8] :
                                                       m.wdataM[8*gi +: 8];
    end
  endgenerate

  // Extension happens at capture time so rdataM holds steady after DONE.
  always_comb begin
    ld_half = lo_q[1] ? m.bus_rdata[31:16] : m.bus_rdata[15:0];
    case (lo_q)
      2'd0:    ld_byte = m.bus_rdata[7:0];
      2'd1:    ld_byte = m.bus_rdata[15:8];
      2'd2:    ld_byte = m.bus_rdata[23:16];
      default: ld_byte = m.bus_rdata[31:24];
    endcase
    case (size_q)
      2'b00:   rdata_d = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   rdata_d = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: rdata_d = m.bus_rdata;
    endcase
    if (wr_q) rdata_d = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = REQ;
      REQ:     if (m.bus_ack) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        wr_q    <= m.memwriteM;
        addr_q  <= {m.addrM[ADDR_W-1:2], 2'b00};
        wstrb_q <= wstrb_d;
        wdata_q <= wdata_d;
        lo_q    <= m.addrM[1:0];
        size_q  <= m.sizeM;
        uns_q   <= m.unsignedM;
      end
      if ((state_q == REQ) && m.bus_ack) rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage data-side controller between the pipeline's M-stage outputs and a request/acknowledge data bus.
- Consumes the address, store data and store-enable that the datapath produces in M. Returns load data in M.
- Generates byte strobes and lane replication for stores, and lane extraction with sign/zero extension for loads.
- Detects misaligned accesses. Stalls the pipeline while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, address width of both the M-stage address and the bus address.
- DATA_W, 32, data width; only 32 is supported (4 byte lanes).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- memenM  in  1  the M-stage instruction is a load or store.
- memwriteM  in  1  1 = store, 0 = load; valid only when memenM=1.
- sizeM  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- unsignedM  in  1  1 = zero-extend the load result, 0 = sign-extend it.
- addrM  in  ADDR_W  byte address (the ALU result in M).
- wdataM  in  DATA_W  store data, right-aligned.
- rdataM  out  DATA_W  extended load result; valid in the DONE cycle.
- stall_mem  out  1  holds every pipeline stage at or before M.
- adelM  out  1  load address error (misaligned load).
- adesM  out  1  store address error (misaligned store).
- bus_req  out  1  bus request.
- bus_wr  out  1  1 = bus write.
- bus_addr  out  ADDR_W  word-aligned address, {addrM[ADDR_W-1:2],2'b00}.
- bus_wstrb  out  4  byte-lane write strobes; all 0 for reads.
- bus_wdata  out  DATA_W  lane-replicated store data.
- bus_ack  in  1  transfer complete; bus_rdata is valid in the same cycle.
- bus_rdata  in  DATA_W  raw word read from the bus.

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset enters IDLE.
- Reset values: all outputs 0, captured read word 0, state IDLE. Assertion mid-transaction drops bus_req asynchronously and abandons the access.
- Misalignment (combinational):
  - mis = (size=01 & addr[0]) | (size>=10 & addr[1:0]!=0).
  - adelM = memenM & ~memwriteM & mis & state==IDLE.
  - adesM = memenM & memwriteM & mis & state==IDLE.
  - A misaligned access issues no bus transaction and raises no stall.
- IDLE:
  - If memenM & ~mis: register bus_wr, bus_addr, bus_wstrb, bus_wdata, addr[1:0], size and unsigned; next state REQ.
  - stall_mem = memenM & ~mis, combinational, in this cycle.
- REQ:
  - bus_req=1 and stall_mem=1.
  - All bus outputs stay stable until bus_ack is sampled 1.
  - On bus_ack: capture bus_rdata; next state DONE. The ack may arrive in the first REQ cycle; the wait is unbounded.
- DONE:
  - stall_mem=0, bus_req=0, rdataM valid; the pipeline advances at this edge.
  - Next state is unconditionally IDLE. memenM is ignored in DONE, so the same instruction is never re-issued.
- Minimum M-stage residence for an access is 3 cycles (stall high for 2).
- Store strobes and data (little-endian):
  - byte: wstrb = 4'b0001<<addr[1:0], wdata = {4{wdataM[7:0]}}.
  - half: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdataM[15:0]}}.
  - word: wstrb = 4'b1111, wdata = wdataM.
  - Reads drive wstrb = 0.
- Load extraction from the captured word:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - word: whole word.
  - Extension per unsignedM.
  - rdataM = 0 for stores.
  - rdataM is held from the DONE cycle until the next capture.

Test Plan:
- Aligned lw from 0x100 with ack in the first REQ cycle, bus_rdata 0xDEADBEEF → stall_mem high 2 cycles; rdataM = 0xDEADBEEF in DONE; bus_addr 0x100; wstrb 0.
- lb from 0x103 signed, then lbu from 0x103, bus_rdata 0x80112233 → rdataM 0xFFFFFF80, then 0x00000080.
- sh to 0x102 with wdataM 0x0000ABCD and ack after 5 wait cycles → wstrb 1100, bus_wdata 0xABCDABCD, bus signals stable across all waits, stall_mem high 7 cycles.
- lw at 0x101 → adelM=1, stall_mem=0, bus_req never asserted. sw at 0x102 → adesM=1, no bus request.
- Back-to-back sb 0x200 then lh 0x202 (memenM held through DONE) → exactly 2 bus transactions, no duplicate request in DONE.
- rst driven to 0 while in REQ → bus_req drops immediately, state IDLE, all outputs 0. After release, a new lw completes normally.
